io_intr_ctrl: RTL and testbench
===============================

Name: io_intr_ctrl

Overview:
- Sequences the CPU's I/O and interrupt resources: the input register path, the output register path, the FGI/FGO flags, IEN and the interrupt flip-flop R.
- Sits between the control unit and the external input/output devices.
- Devices use valid/ready handshakes; the control unit sees flags, the INPR value and an interrupt request.

Parameters:
- WIDTH, 16, data width of the input/output words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- dev_in_valid  input  1  input device offers a word
- dev_in_data  input  WIDTH  input device word
- dev_in_ready  output  1  controller can accept an input word (equals !fgi)
- dev_out_valid  output  1  output word pending to the device
- dev_out_data  output  WIDTH  output word
- dev_out_ready  input  1  output device accepts the word
- inp_take  input  1  INP instruction executing; AC loads inpr this cycle
- out_load  input  1  OUT instruction executing; out_data is valid
- out_data  input  WIDTH  bus value for OUT
- ion  input  1  ION instruction
- iof  input  1  IOF instruction
- r_window  input  1  control unit outside fetch timing (not T0..T2)
- int_ack  input  1  interrupt cycle completing
- inpr  output  WIDTH  captured input word
- fgi  output  1  input flag
- fgo  output  1  output flag
- ien  output  1  interrupt enable
- int_req  output  1  R flip-flop; the control unit enters the interrupt cycle on the next fetch
- out_overrun  output  1  sticky error flag

Behaviour:
- Reset values, all on a synchronous reset: fgi=0, fgo=1, ien=0, int_req=0, dev_out_valid=0, dev_out_data=0, inpr=0, out_overrun=0.
- dev_in_ready = !fgi (combinational).
- Reset has priority over every other event, including reset mid-handshake. A pending output word is dropped.
- Input channel, states IN_EMPTY (fgi=0) and IN_FULL (fgi=1):
  - IN_EMPTY and dev_in_valid: inpr <= dev_in_data and fgi <= 1 at the edge. Visible the next cycle.
  - IN_FULL and inp_take: fgi <= 0. dev_in_ready rises the next cycle.
  - A word is never captured in the same cycle it is taken, so there is one cycle of minimum spacing.
  - inp_take while IN_EMPTY: no effect.
- Output channel, states OUT_IDLE (fgo=1) and OUT_BUSY (fgo=0, dev_out_valid=1):
  - OUT_IDLE and out_load: dev_out_data <= out_data, dev_out_valid <= 1, fgo <= 0.
  - OUT_BUSY and dev_out_ready: dev_out_valid <= 0, fgo <= 1.
  - dev_out_data stays stable while valid.
  - out_load while OUT_BUSY: data is ignored and out_overrun <= 1 (sticky until reset).
  - If out_load and dev_out_ready coincide in OUT_BUSY, the handshake completes and out_overrun is set; the new word is not taken.
- IEN:
  - ion sets it and iof clears it.
  - iof wins over ion in the same cycle.
  - int_ack clears it and wins over ion.
- R (int_req):
  - Set when r_window & ien & (fgi | fgo) & !int_ack.
  - Holds until int_ack, which clears it next edge.
  - Set uses current-cycle register values. Flag changes in the same cycle affect R one cycle later.
- No combinational path from device inputs to the CPU-side outputs.

Decomposition:
- Package cpu_io_pkg holds:
  - the WIDTH default;
  - the in-state enum {IN_EMPTY, IN_FULL} and out-state enum {OUT_IDLE, OUT_BUSY}, 1-bit each;
  - FGO_RESET = 1.
- One sub-module is natural: io_out_channel (output handshake FSM, data holding register, overrun flag).
- Input channel and interrupt logic stay in the top module.

Test Plan:
- After reset: check fgi=0, fgo=1, ien=0, int_req=0, dev_in_ready=1. Drive dev_in_valid with 16'hA5C3 → next cycle inpr=16'hA5C3, fgi=1, dev_in_ready=0. Pulse inp_take → fgi=0 next cycle. A second word 16'h0001 offered during IN_FULL is not captured until ready returns.
- out_load with 16'h1234 and dev_out_ready=0 for 3 cycles → dev_out_valid=1, dev_out_data=16'h1234 and fgo=0 held 3 cycles. Raise dev_out_ready → valid=0 and fgo=1 next cycle.
- In OUT_BUSY, out_load with 16'hFFFF → out_overrun=1 and dev_out_data stays 16'h1234. Reset → out_overrun=0, fgo=1.
- ion, then r_window=1 with fgo=1 → int_req=1 next cycle. Pulse int_ack → int_req=0 and ien=0; R is not re-set while ien=0.
- ion and iof in the same cycle → ien=0. ien=1, then int_ack and ion in the same cycle → ien=0.
- Assert reset during OUT_BUSY and IN_FULL with int_req=1 → all outputs at reset values the next cycle, with no device handshake completing.

Source files
------------

// File: rtl/cpu_io_pkg.sv
// Shared types and constants for the CPU I/O and interrupt controller.
// Each channel state is a single bit, so each flag is a direct decode of its state.
package cpu_io_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic {
    IN_EMPTY = 1'b0,
    IN_FULL  = 1'b1
  } in_state_e;

  typedef enum logic {
    OUT_IDLE = 1'b0,
    OUT_BUSY = 1'b1
  } out_state_e;

  // Output flag comes out of reset set: the device side is idle.
  localparam logic FGO_RESET = 1'b1;

endpackage

// File: rtl/io_out_channel.sv
// Output-device channel: OUT word holding register, valid/ready handshake and FGO.
// A load while a word is still pending is dropped and raises a sticky overrun flag.
module io_out_channel
  import cpu_io_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dev_ready,
  output logic             dev_valid,
  output logic [WIDTH-1:0] dev_data,
  output logic             fgo,
  output logic             overrun
);

  out_state_e       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             overrun_q, overrun_d;

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    overrun_d = overrun_q;
    unique case (state_q)
      OUT_IDLE: begin
        if (load) begin
          state_d = OUT_BUSY;
          data_d  = load_data;
        end
      end
      OUT_BUSY: begin
        // The pending word has precedence; a colliding load is never taken.
        if (load) begin
          overrun_d = 1'b1;
        end
        if (dev_ready) begin
          state_d = OUT_IDLE;
        end
      end
      default: state_d = OUT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FGO_RESET ? OUT_IDLE : OUT_BUSY;
      data_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      overrun_q <= overrun_d;
    end
  end

  assign dev_valid = (state_q == OUT_BUSY);
  assign dev_data  = data_q;
  assign fgo       = (state_q == OUT_IDLE);
  assign overrun   = overrun_q;

endmodule

// File: rtl/io_intr_ctrl.sv
// CPU I/O and interrupt sequencing: INPR/FGI input channel, output channel, IEN and R.
// Every CPU-side output is a register or a decode of one, so device inputs never reach them.
module io_intr_ctrl
  import cpu_io_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dev_in_valid,
  input  logic [WIDTH-1:0] dev_in_data,
  output logic             dev_in_ready,
  output logic             dev_out_valid,
  output logic [WIDTH-1:0] dev_out_data,
  input  logic             dev_out_ready,
  input  logic             inp_take,
  input  logic             out_load,
  input  logic [WIDTH-1:0] out_data,
  input  logic             ion,
  input  logic             iof,
  input  logic             r_window,
  input  logic             int_ack,
  output logic [WIDTH-1:0] inpr,
  output logic             fgi,
  output logic             fgo,
  output logic             ien,
  output logic             int_req,
  output logic             out_overrun
);

  in_state_e        in_state_q, in_state_d;
  logic [WIDTH-1:0] inpr_q, inpr_d;
  logic             ien_q, ien_d;
  logic             r_q, r_d;
  logic             fgo_w;

  // Input channel: capture only when empty, release only when full, so a
  // capture and a take never share a cycle.
  always_comb begin
    in_state_d = in_state_q;
    inpr_d     = inpr_q;
    unique case (in_state_q)
      IN_EMPTY: begin
        if (dev_in_valid) begin
          in_state_d = IN_FULL;
          inpr_d     = dev_in_data;
        end
      end
      IN_FULL: begin
        if (inp_take) begin
          in_state_d = IN_EMPTY;
        end
      end
      default: in_state_d = IN_EMPTY;
    endcase
  end

  // IEN: clears (IOF or interrupt acknowledge) win over ION.
  always_comb begin
    ien_d = ien_q;
    if (iof || int_ack) begin
      ien_d = 1'b0;
    end else if (ion) begin
      ien_d = 1'b1;
    end
  end

  // R looks at registered flags only; same-cycle flag updates show up next cycle.
  always_comb begin
    r_d = r_q;
    if (int_ack) begin
      r_d = 1'b0;
    end else if (r_window && ien_q && (fgi || fgo_w)) begin
      r_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_state_q <= IN_EMPTY;
      inpr_q     <= '0;
      ien_q      <= 1'b0;
      r_q        <= 1'b0;
    end else begin
      in_state_q <= in_state_d;
      inpr_q     <= inpr_d;
      ien_q      <= ien_d;
      r_q        <= r_d;
    end
  end

  io_out_channel #(
    .WIDTH (WIDTH)
  ) u_out_channel (
    .clk       (clk),
    .reset     (reset),
    .load      (out_load),
    .load_data (out_data),
    .dev_ready (dev_out_ready),
    .dev_valid (dev_out_valid),
    .dev_data  (dev_out_data),
    .fgo       (fgo_w),
    .overrun   (out_overrun)
  );

  assign fgi          = (in_state_q == IN_FULL);
  assign dev_in_ready = ~fgi;
  assign inpr         = inpr_q;
  assign fgo          = fgo_w;
  assign ien          = ien_q;
  assign int_req      = r_q;

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed and randomized bench for io_intr_ctrl against a flag-level behavioural model.
module tb_io_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        dev_in_valid;
  logic [15:0] dev_in_data;
  logic        dev_in_ready;
  logic        dev_out_valid;
  logic [15:0] dev_out_data;
  logic        dev_out_ready;
  logic        inp_take;
  logic        out_load;
  logic [15:0] out_data;
  logic        ion;
  logic        iof;
  logic        r_window;
  logic        int_ack;
  logic [15:0] inpr;
  logic        fgi;
  logic        fgo;
  logic        ien;
  logic        int_req;
  logic        out_overrun;

  int checks = 0;
  int errors = 0;

  // Model: what the CPU would observe, as plain flags and words.
  logic        m_fgi, m_fgo, m_ien, m_r, m_ovr;
  logic [15:0] m_inpr, m_out_word;

  always #5 clk = ~clk;

  io_intr_ctrl #(
    .WIDTH (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dev_in_valid  (dev_in_valid),
    .dev_in_data   (dev_in_data),
    .dev_in_ready  (dev_in_ready),
    .dev_out_valid (dev_out_valid),
    .dev_out_data  (dev_out_data),
    .dev_out_ready (dev_out_ready),
    .inp_take      (inp_take),
    .out_load      (out_load),
    .out_data      (out_data),
    .ion           (ion),
    .iof           (iof),
    .r_window      (r_window),
    .int_ack       (int_ack),
    .inpr          (inpr),
    .fgi           (fgi),
    .fgo           (fgo),
    .ien           (ien),
    .int_req       (int_req),
    .out_overrun   (out_overrun)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance the model by one clock using the inputs that are being applied now.
  task automatic model_edge();
    logic n_fgi, n_fgo, n_ien, n_r, n_ovr;
    logic [15:0] n_inpr, n_word;
    if (reset) begin
      n_fgi = 0; n_fgo = 1; n_ien = 0; n_r = 0; n_ovr = 0; n_inpr = 0; n_word = 0;
    end else begin
      n_fgi = m_fgi; n_inpr = m_inpr;
      if (!m_fgi && dev_in_valid) begin
        n_fgi = 1; n_inpr = dev_in_data;
      end else if (m_fgi && inp_take) begin
        n_fgi = 0;
      end
      n_fgo = m_fgo; n_word = m_out_word; n_ovr = m_ovr;
      if (m_fgo) begin
        if (out_load) begin
          n_fgo = 0; n_word = out_data;
        end
      end else begin
        if (out_load) n_ovr = 1;
        if (dev_out_ready) n_fgo = 1;
      end
      n_ien = (iof || int_ack) ? 1'b0 : (ion ? 1'b1 : m_ien);
      n_r = int_ack ? 1'b0 : ((r_window && m_ien && (m_fgi || m_fgo)) ? 1'b1 : m_r);
    end
    m_fgi = n_fgi; m_fgo = n_fgo; m_ien = n_ien; m_r = n_r; m_ovr = n_ovr;
    m_inpr = n_inpr; m_out_word = n_word;
  endtask

  task automatic check_all(input string where);
    check({where, ".inpr"}, inpr, m_inpr);
    check({where, ".fgi"}, 16'(fgi), 16'(m_fgi));
    check({where, ".dev_in_ready"}, 16'(dev_in_ready), 16'(!m_fgi));
    check({where, ".fgo"}, 16'(fgo), 16'(m_fgo));
    check({where, ".dev_out_valid"}, 16'(dev_out_valid), 16'(!m_fgo));
    check({where, ".dev_out_data"}, dev_out_data, m_out_word);
    check({where, ".ien"}, 16'(ien), 16'(m_ien));
    check({where, ".int_req"}, 16'(int_req), 16'(m_r));
    check({where, ".out_overrun"}, 16'(out_overrun), 16'(m_ovr));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  initial begin
    reset = 1; dev_in_valid = 0; dev_in_data = 0; dev_out_ready = 0; inp_take = 0;
    out_load = 0; out_data = 0; ion = 0; iof = 0; r_window = 0; int_ack = 0;
    m_fgi = 0; m_fgo = 1; m_ien = 0; m_r = 0; m_ovr = 0; m_inpr = 0; m_out_word = 0;
    #1;
    step("reset");
    reset = 0;
    check("rst_fgi", 16'(fgi), 16'd0);
    check("rst_fgo", 16'(fgo), 16'd1);
    check("rst_ien", 16'(ien), 16'd0);
    check("rst_int_req", 16'(int_req), 16'd0);
    check("rst_ready", 16'(dev_in_ready), 16'd1);

    // Input capture, hold while full, release on INP.
    dev_in_valid = 1; dev_in_data = 16'hA5C3;
    step("in_cap");
    check("in_inpr", inpr, 16'hA5C3);
    check("in_fgi", 16'(fgi), 16'd1);
    check("in_ready", 16'(dev_in_ready), 16'd0);
    dev_in_data = 16'h0001;
    step("in_full_hold");
    check("in_no_overwrite", inpr, 16'hA5C3);
    inp_take = 1;
    step("in_take");
    inp_take = 0;
    check("in_take_fgi", 16'(fgi), 16'd0);
    check("in_take_inpr", inpr, 16'hA5C3);
    step("in_second");
    check("in_second_inpr", inpr, 16'h0001);
    dev_in_valid = 0; inp_take = 1;
    step("in_drain");
    inp_take = 0;

    // Output handshake with a stalled device.
    out_load = 1; out_data = 16'h1234;
    step("out_load");
    out_load = 0;
    for (int i = 0; i < 3; i++) begin
      step("out_stall");
      check("out_hold_valid", 16'(dev_out_valid), 16'd1);
      check("out_hold_data", dev_out_data, 16'h1234);
      check("out_hold_fgo", 16'(fgo), 16'd0);
    end
    dev_out_ready = 1;
    step("out_done");
    dev_out_ready = 0;
    check("out_done_valid", 16'(dev_out_valid), 16'd0);
    check("out_done_fgo", 16'(fgo), 16'd1);

    // Overrun while busy, then cleared by reset.
    out_load = 1; out_data = 16'h1234;
    step("ovr_load");
    out_data = 16'hFFFF;
    step("ovr_hit");
    out_load = 0;
    check("ovr_flag", 16'(out_overrun), 16'd1);
    check("ovr_data", dev_out_data, 16'h1234);
    reset = 1;
    step("ovr_reset");
    reset = 0;
    check("ovr_cleared", 16'(out_overrun), 16'd0);
    check("ovr_fgo", 16'(fgo), 16'd1);

    // Interrupt request and acknowledge.
    ion = 1;
    step("ion");
    ion = 0; r_window = 1;
    step("r_set");
    check("r_set", 16'(int_req), 16'd1);
    int_ack = 1;
    step("r_ack");
    int_ack = 0;
    check("r_ack_req", 16'(int_req), 16'd0);
    check("r_ack_ien", 16'(ien), 16'd0);
    step("r_quiet1");
    step("r_quiet2");
    check("r_stays_low", 16'(int_req), 16'd0);
    r_window = 0;

    // IEN priority.
    ion = 1; iof = 1;
    step("ion_iof");
    iof = 0;
    check("iof_wins", 16'(ien), 16'd0);
    step("ion_only");
    check("ion_sets", 16'(ien), 16'd1);
    int_ack = 1;
    step("ion_ack");
    ion = 0; int_ack = 0;
    check("ack_wins", 16'(ien), 16'd0);

    // Reset mid-handshake with everything active.
    dev_in_valid = 1; dev_in_data = 16'h5A5A; out_load = 1; out_data = 16'hBEEF; ion = 1;
    step("setup");
    dev_in_valid = 0; out_load = 0; ion = 0; r_window = 1;
    step("setup_r");
    check("setup_r", 16'(int_req), 16'd1);
    reset = 1; dev_out_ready = 1; inp_take = 1; dev_in_valid = 1;
    step("mid_reset");
    check("mr_fgi", 16'(fgi), 16'd0);
    check("mr_fgo", 16'(fgo), 16'd1);
    check("mr_valid", 16'(dev_out_valid), 16'd0);
    check("mr_data", dev_out_data, 16'h0000);
    check("mr_inpr", inpr, 16'h0000);
    check("mr_r", 16'(int_req), 16'd0);
    reset = 0; dev_out_ready = 0; inp_take = 0; dev_in_valid = 0; r_window = 0;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 99) == 0);
      dev_in_valid  = $urandom_range(0, 1);
      dev_in_data   = 16'($urandom);
      dev_out_ready = ($urandom_range(0, 2) == 0);
      inp_take      = ($urandom_range(0, 2) == 0);
      out_load      = ($urandom_range(0, 3) == 0);
      out_data      = 16'($urandom);
      ion           = ($urandom_range(0, 4) == 0);
      iof           = ($urandom_range(0, 9) == 0);
      r_window      = $urandom_range(0, 1);
      int_ack       = ($urandom_range(0, 7) == 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
